// File: rtl/mem_access_unit_if.sv
// Core request/response and data-memory signals of the memory access unit.
// The unit connects through the slave modport; the core/memory side uses master.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide memory, with
// sign/zero extension on loads and read-modify-write for sub-word stores.
module mem_access_unit (
    input logic               clk,
    input logic               reset,
    mem_access_unit_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] RMW_RD = 2'd2;
    localparam logic [1:0] WRITE  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_addr;
    logic [31:0] merge;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        accept;
    logic        req_err;
    logic [31:0] byte_lane;
    logic [31:0] half_lane;
    logic [31:0] load_data;
    logic [31:0] merge_next;

    assign bus.req_ready  = (state == IDLE);
    assign accept         = bus.req_valid & bus.req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_rdata;
    assign bus.resp_err   = resp_err;
    assign bus.mem_a      = (state == IDLE) ? '0 : {lat_addr[31:2], 2'b00};
    assign bus.mem_we     = (state == WRITE);
    assign bus.mem_wd     = (state == WRITE) ? merge : '0;

    always_comb begin
        req_err = (bus.req_size == 2'b11)
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    end

    always_comb begin
        byte_lane = bus.mem_rd >> {lat_addr[1:0], 3'b000};
        half_lane = bus.mem_rd >> {lat_addr[1], 4'b0000};
        case (lat_size)
            2'b00:   load_data = {{24{lat_signed & byte_lane[7]}}, byte_lane[7:0]};
            2'b01:   load_data = {{16{lat_signed & half_lane[15]}}, half_lane[15:0]};
            default: load_data = bus.mem_rd;
        endcase
    end

    // merge holds the right-aligned store data until RMW_RD folds it into mem_rd
    always_comb begin
        merge_next = bus.mem_rd;
        if (lat_size == 2'b00)
            merge_next[{lat_addr[1:0], 3'b000} +: 8] = merge[7:0];
        else
            merge_next[{lat_addr[1], 4'b0000} +: 16] = merge[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_size   <= '0;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            merge      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_size   <= bus.req_size;
                        lat_signed <= bus.req_signed;
                        lat_addr   <= bus.req_addr;
                        merge      <= bus.req_wdata;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!bus.req_we) begin
                            state <= LOAD;
                        end else if (bus.req_size == 2'b10) begin
                            state <= WRITE;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_data;
                    state      <= IDLE;
                end
                RMW_RD: begin
                    merge <= merge_next;
                    state <= WRITE;
                end
                default: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-wide memory model and
// hand-computed expected load results, merge words and latencies.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [31:0] mem_arr [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_idx = '0;
    logic [31:0] pl_data = '0;
    int          we_count = 0;
    int          resp_count = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_wd = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign bus.mem_rd = mem_arr[bus.mem_a[13:2]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem_arr[bus.mem_a[13:2]] <= bus.mem_wd;
            we_count <= we_count + 1;
            last_a   <= bus.mem_a;
            last_wd  <= bus.mem_wd;
        end else if (pl_en) begin
            mem_arr[pl_idx] <= pl_data;
        end
        if (bus.resp_valid) resp_count <= resp_count + 1;
    end

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pl_idx  = addr[13:2];
        pl_data = data;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    // Presents one request and counts cycles, starting with the accept cycle,
    // until resp_valid is seen; lat = 0 means no response within the budget.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, output int lat);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            if (bus.resp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
        n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.resp_err); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
        n_cmp++; if (bus.mem_a !== 32'h0) begin n_bad++; $display("FAIL rst_mem_a: got %h want 0", bus.mem_a); end
        n_cmp++; if (bus.mem_wd !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wd: got %h want 0", bus.mem_wd); end
    endtask

    task automatic test_first_accept();
        int lat;
        preload(32'h1000, 32'h8899AABB);
        @(posedge clk); #1;
        reset = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL first_lat: got %0d want 2", lat); end
        n_cmp++; if (bus.resp_rdata !== 32'h8899AABB) begin n_bad++; $display("FAIL first_rdata: got %h want 8899aabb", bus.resp_rdata); end
    endtask

    typedef struct {
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] exp;
    } load_vec_t;

    task automatic test_loads();
        load_vec_t v[9] = '{
            '{2'b00, 1'b1, 32'h1002, 32'h8899AABB, 32'hFFFFFF99},
            '{2'b00, 1'b0, 32'h1002, 32'h8899AABB, 32'h00000099},
            '{2'b00, 1'b0, 32'h1000, 32'h8899AABB, 32'h000000BB},
            '{2'b00, 1'b1, 32'h1003, 32'h8899AABB, 32'hFFFFFF88},
            '{2'b00, 1'b1, 32'h1001, 32'h8899AABB, 32'hFFFFFFAA},
            '{2'b01, 1'b1, 32'h1002, 32'h80017FFF, 32'hFFFF8001},
            '{2'b01, 1'b1, 32'h1000, 32'h80017FFF, 32'h00007FFF},
            '{2'b01, 1'b0, 32'h1002, 32'h80017FFF, 32'h00008001},
            '{2'b10, 1'b1, 32'h1000, 32'h80017FFF, 32'h80017FFF}
        };
        int lat;
        foreach (v[i]) begin
            preload(v[i].addr, v[i].word);
            do_req(1'b0, v[i].size, v[i].sgn, v[i].addr, 32'h0, lat);
            n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL load%0d_lat: got %0d want 2", i, lat); end
            n_cmp++; if (bus.resp_rdata !== v[i].exp) begin n_bad++; $display("FAIL load%0d_rdata: got %h want %h", i, bus.resp_rdata, v[i].exp); end
            n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL load%0d_err: got %b want 0", i, bus.resp_err); end
        end
        @(posedge clk); #1;
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL load_pulse: got %b want 0", bus.resp_valid); end
        n_cmp++; if (bus.resp_rdata !== 32'h80017FFF) begin n_bad++; $display("FAIL load_hold: got %h want 80017fff", bus.resp_rdata); end
    endtask

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } store_vec_t;

    task automatic test_stores();
        store_vec_t v[4] = '{
            '{2'b00, 32'h1001, 32'h11223344, 32'h000000A5, 32'h1122A544, 3},
            '{2'b01, 32'h1002, 32'h80017FFF, 32'h0000BEEF, 32'hBEEF7FFF, 3},
            '{2'b00, 32'h1003, 32'h11223344, 32'h12345677, 32'h77223344, 3},
            '{2'b10, 32'h1000, 32'h11223344, 32'hCAFEF00D, 32'hCAFEF00D, 2}
        };
        int lat;
        int we0;
        foreach (v[i]) begin
            preload(v[i].addr, v[i].word);
            we0 = we_count;
            do_req(1'b1, v[i].size, 1'b0, v[i].addr, v[i].wdata, lat);
            n_cmp++; if (lat !== v[i].lat) begin n_bad++; $display("FAIL store%0d_lat: got %0d want %0d", i, lat, v[i].lat); end
            n_cmp++; if (we_count - we0 !== 1) begin n_bad++; $display("FAIL store%0d_pulses: got %0d want 1", i, we_count - we0); end
            n_cmp++; if (last_a !== 32'h1000) begin n_bad++; $display("FAIL store%0d_addr: got %h want 00001000", i, last_a); end
            n_cmp++; if (last_wd !== v[i].exp) begin n_bad++; $display("FAIL store%0d_wd: got %h want %h", i, last_wd, v[i].exp); end
            n_cmp++; if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL store%0d_resp: got %h/%b want 0/0", i, bus.resp_rdata, bus.resp_err); end
            n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_wd !== 32'h0) begin n_bad++; $display("FAIL store%0d_idle_bus: got %b/%h want 0/0", i, bus.mem_we, bus.mem_wd); end
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
    } err_vec_t;

    task automatic test_errors();
        err_vec_t v[5] = '{
            '{1'b1, 2'b01, 32'h1003},
            '{1'b0, 2'b10, 32'h1002},
            '{1'b0, 2'b11, 32'h1000},
            '{1'b1, 2'b11, 32'h1000},
            '{1'b0, 2'b01, 32'h1001}
        };
        int lat;
        int we0;
        preload(32'h1000, 32'h8899AABB);
        do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat);
        foreach (v[i]) begin
            we0 = we_count;
            do_req(v[i].we, v[i].size, 1'b1, v[i].addr, 32'hFFFFFFFF, lat);
            n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL err%0d_lat: got %0d want 1", i, lat); end
            n_cmp++; if (bus.resp_err !== 1'b1) begin n_bad++; $display("FAIL err%0d_flag: got %b want 1", i, bus.resp_err); end
            n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL err%0d_rdata: got %h want 0", i, bus.resp_rdata); end
            @(posedge clk); #1;
            n_cmp++; if (we_count !== we0) begin n_bad++; $display("FAIL err%0d_no_write: got %0d pulses want 0", i, we_count - we0); end
        end
        n_cmp++; if (mem_arr[1024] !== 32'h8899AABB) begin n_bad++; $display("FAIL err_mem: got %h want 8899aabb", mem_arr[1024]); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_req(1'b1, 2'b10, 1'b0, 32'h2000, 32'hDEADBEEF, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL b2b_st_lat: got %0d want 2", lat); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", bus.req_ready); end
        do_req(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL b2b_ld_lat: got %0d want 2", lat); end
        n_cmp++; if (bus.resp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_rdata: got %h want deadbeef", bus.resp_rdata); end
    endtask

    task automatic test_rmw_reset();
        int we0;
        int rc0;
        preload(32'h1000, 32'h11223344);
        we0 = we_count;
        rc0 = resp_count;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h1001; bus.req_wdata = 32'hA5;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rmw_busy: got %b want 0", bus.req_ready); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rmw_rst_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_a !== 32'h0) begin n_bad++; $display("FAIL rmw_rst_bus: got %b/%h want 0/0", bus.mem_we, bus.mem_a); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (we_count !== we0) begin n_bad++; $display("FAIL rmw_rst_we: got %0d pulses want 0", we_count - we0); end
        n_cmp++; if (resp_count !== rc0) begin n_bad++; $display("FAIL rmw_rst_resp: got %0d responses want 0", resp_count - rc0); end
        n_cmp++; if (mem_arr[1024] !== 32'h11223344) begin n_bad++; $display("FAIL rmw_rst_mem: got %h want 11223344", mem_arr[1024]); end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        test_reset();
        test_first_accept();
        test_loads();
        test_stores();
        test_errors();
        test_back_to_back();
        test_rmw_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock; the single clock for all state.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: req_valid  input  1  core presents a memory request.
REQ-004 SHALL: req_we  input  1  1 = store, 0 = load.
REQ-005 SHALL: req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-006 SHALL: req_signed  input  1  loads only; 1 = sign-extend, 0 = zero-extend.
REQ-007 SHALL: req_addr  input  32  byte address.
REQ-008 SHALL: req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL: req_ready  output  1  unit accepts a request this cycle.
REQ-010 SHALL: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL: resp_rdata  output  32  load result; 0 for stores and errors.
REQ-012 SHALL: resp_err  output  1  misaligned or illegal-size request; valid with resp_valid.
REQ-013 SHALL: mem_we  output  1  data memory write enable.
REQ-014 SHALL: mem_a  output  32  data memory byte address, always word-aligned ([1:0]=00).
REQ-015 SHALL: mem_wd  output  32  data memory write data.
REQ-016 SHALL: mem_rd  input  32  data memory read data, combinational from mem_a.

Function
REQ-017 SHALL: FSM states IDLE, LOAD, RMW_RD, WRITE; req_ready = 1 only in IDLE.
REQ-018 SHALL: accept = req_valid & req_ready; on accept latch we, size, signed, addr, wdata.
REQ-019 SHALL: error when size=11, or size=01 & addr[0]=1, or size=10 & addr[1:0]!=00; errored accept stays IDLE and sets resp_valid=1, resp_err=1, resp_rdata=0 at the next edge; no memory access.
REQ-020 SHALL: legal load accept -> LOAD; legal word store -> WRITE; legal byte/half store -> RMW_RD.
REQ-021 SHALL: in LOAD, RMW_RD and WRITE, mem_a = {latched_addr[31:2],2'b00}; in IDLE mem_a = 0.
REQ-022 SHALL: LOAD: at the edge, resp_rdata = extracted/extended lane of mem_rd, resp_valid=1, resp_err=0; next state IDLE.
REQ-023 SHALL: lanes are little-endian: byte k = addr[1:0] occupies bits [8k+7:8k]; half h = addr[1] occupies bits [16h+15:16h].
REQ-024 SHALL: RMW_RD: at the edge, merge register = mem_rd with the addressed lane replaced by the latched wdata lane; next state WRITE.
REQ-025 SHALL: word store: merge register = latched wdata on accept.
REQ-026 SHALL: WRITE: mem_we=1, mem_wd = merge register for exactly one cycle; at the edge resp_valid=1, resp_rdata=0, resp_err=0; next state IDLE.
REQ-027 SHALL: mem_we=0 and mem_wd=0 in every state except WRITE.
REQ-028 SHALL: latency from accept edge to resp_valid: error 1 cycle, load 2, word store 2, byte/half store 3.
REQ-029 SHALL: resp_valid is high for one cycle only; resp_rdata/resp_err hold until the next response.
REQ-030 SHALL: a new request may be accepted in the same cycle resp_valid is high (back-to-back, no bubble).
REQ-031 SHALL: req_* inputs are ignored outside IDLE; no queueing.

Reset
REQ-032 SHALL: reset asserted forces, without waiting for clk: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, merge register and latched request 0.
REQ-033 SHALL: reset during LOAD/RMW_RD/WRITE abandons the operation; no response and no further mem_we pulse.
REQ-034 SHALL: first accept is possible on the first rising edge after reset deasserts.

Verification
REQ-035 SHALL: word 0x1000 holds 0x8899AABB; signed byte load at 0x1002 -> resp_rdata 0xFFFFFF99 two cycles after accept; unsigned -> 0x00000099.
REQ-036 SHALL: word 0x1000 = 0x11223344; byte store 0xA5 at 0x1001 -> single mem_we pulse with mem_a 0x1000, mem_wd 0x1122A544; resp 3 cycles after accept.
REQ-037 SHALL: half store at 0x1003 or word load at 0x1002 or size 11 -> resp_err=1 one cycle later, mem_we never asserted.
REQ-038 SHALL: word store 0xDEADBEEF at 0x2000 immediately followed by word load 0x2000 accepted in the resp_valid cycle -> load returns 0xDEADBEEF.
REQ-039 SHALL: reset asserted in RMW_RD -> mem_we stays 0, memory word unchanged, req_ready=1 immediately, no resp_valid.
REQ-040 SHALL: halfword signed load at 0x1002 of word 0x80017FFF -> 0xFFFF8001; at 0x1000 -> 0x00007FFF.
